vector_adder_subtractor: RTL and testbench

//   Lane-wise SIMD integer adder/subtractor for the vector execution unit.

---
 rtl/vector_pkg.sv | 46 ++++
 rtl/vector_adder_subtractor_if.sv | 24 ++
 rtl/vector_adder_subtractor_byte_slice.sv | 23 ++
 rtl/vector_adder_subtractor.sv | 111 +++++++++++
 tb/tb_vector_adder_subtractor.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/vector_pkg.sv
// Shared types and helpers for the lane-wise vector adder/subtractor.
// Vector width is fixed here; lanes are 8/16/32 bits and built from byte slices.
package vector_pkg;

    localparam int unsigned MAX_VLEN   = 4096;
    localparam int unsigned BYTE_LANES = MAX_VLEN / 8;

    typedef logic [MAX_VLEN-1:0] vec_t;

    typedef enum logic [1:0] {
        SEW8  = 2'd0,
        SEW16 = 2'd1,
        SEW32 = 2'd2
    } sew_e;

    // sew_32 only matters once sew_16_32 selects the wide lane sizes.
    function automatic sew_e decode_sew(input logic sew_16_32, input logic sew_32);
        if (!sew_16_32) begin
            return SEW8;
        end
        return sew_32 ? SEW32 : SEW16;
    endfunction

    // Byte idx is the least significant byte of a lane.
    function automatic logic lane_start(input sew_e sew, input int unsigned idx);
        logic res;
        unique case (sew)
            SEW16:   res = ((idx % 2) == 0);
            SEW32:   res = ((idx % 4) == 0);
            default: res = 1'b1;
        endcase
        return res;
    endfunction

    // Byte idx is the most significant (sign) byte of a lane.
    function automatic logic lane_top(input sew_e sew, input int unsigned idx);
        logic res;
        unique case (sew)
            SEW16:   res = ((idx % 2) == 1);
            SEW32:   res = ((idx % 4) == 3);
            default: res = 1'b1;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/vector_adder_subtractor_if.sv
// Operand/control/result bundle between the vector ALU front end and the adder.
interface vector_adder_subtractor_if;
    import vector_pkg::*;

    logic start;
    logic Ctrl;
    logic sew_16_32;
    logic sew_32;
    vec_t A;
    vec_t B;
    vec_t Sum;
    logic sum_done;

    modport master (
        output start, Ctrl, sew_16_32, sew_32, A, B,
        input  Sum, sum_done
    );

    modport slave (
        input  start, Ctrl, sew_16_32, sew_32, A, B,
        output Sum, sum_done
    );

endinterface

// File: rtl/vector_adder_subtractor_byte_slice.sv
// One 8-bit add/subtract slice; B is inverted for subtraction, carry-in supplied by the top.
module vas_byte_slice (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       sub_i,
    input  logic       cin_i,
    output logic [7:0] sum_o,
    output logic       cout_o,
    output logic       ovf_o
);

    logic [7:0] b_eff;
    logic [8:0] full;

    assign b_eff  = sub_i ? ~b_i : b_i;
    assign full   = 9'(a_i) + 9'(b_eff) + 9'(cin_i);
    assign sum_o  = full[7:0];
    assign cout_o = full[8];

    // Signed overflow as seen at this byte's MSB; only meaningful on a lane's top byte.
    assign ovf_o  = (a_i[7] == b_eff[7]) && (full[7] != a_i[7]);

endmodule

// File: rtl/vector_adder_subtractor.sv
// Lane-wise SIMD adder/subtractor with one-cycle registered result.
// Define VADDSUB_SATURATE_EN for signed per-lane saturation instead of modular wrap.
module vector_adder_subtractor
    import vector_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    vector_adder_subtractor_if.slave    bus
);

    sew_e sew_c;
    vec_t res_c;
    vec_t sum_d, sum_q;
    logic done_d, done_q;

    assign sew_c = decode_sew(bus.sew_16_32, bus.sew_32);

    for (genvar i = 0; i < BYTE_LANES; i++) begin : g_byte
        logic       cin;
        logic       cout;
        logic [7:0] raw;
        logic [7:0] res;
`ifdef VADDSUB_SATURATE_EN
        logic       ovf;
`else
        logic       ovf_unused;
`endif

        // Carry restarts with Ctrl at each lane boundary so lanes never interact.
        if (i == 0) begin : g_first
            assign cin = bus.Ctrl;
        end else begin : g_chain
            assign cin = lane_start(sew_c, i) ? bus.Ctrl : g_byte[i-1].cout;
        end

        vas_byte_slice u_slice (
            .a_i    (bus.A[8*i +: 8]),
            .b_i    (bus.B[8*i +: 8]),
            .sub_i  (bus.Ctrl),
            .cin_i  (cin),
            .sum_o  (raw),
            .cout_o (cout),
`ifdef VADDSUB_SATURATE_EN
            .ovf_o  (ovf)
`else
            .ovf_o  (ovf_unused)
`endif
        );

`ifdef VADDSUB_SATURATE_EN
        localparam int unsigned TOP16 = i | 1;
        localparam int unsigned TOP32 = i | 3;

        logic lane_ovf;
        logic lane_neg;

        // Every byte of an overflowing lane takes the clamp value; the sign byte carries 0x7F/0x80.
        always_comb begin
            lane_ovf = ovf;
            lane_neg = bus.A[8*i + 7];
            unique case (sew_c)
                SEW16: begin
                    lane_ovf = g_byte[TOP16].ovf;
                    lane_neg = bus.A[8*TOP16 + 7];
                end
                SEW32: begin
                    lane_ovf = g_byte[TOP32].ovf;
                    lane_neg = bus.A[8*TOP32 + 7];
                end
                default: ;
            endcase

            res = raw;
            if (lane_ovf) begin
                if (lane_top(sew_c, i)) begin
                    res = lane_neg ? 8'h80 : 8'h7F;
                end else begin
                    res = lane_neg ? 8'h00 : 8'hFF;
                end
            end
        end
`else
        assign res = raw;
`endif

        assign res_c[8*i +: 8] = res;
    end

    // Capture on start; result holds otherwise.
    always_comb begin
        sum_d  = sum_q;
        done_d = bus.start;
        if (bus.start) begin
            sum_d = res_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q  <= '0;
            done_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            done_q <= done_d;
        end
    end

    assign bus.Sum      = sum_q;
    assign bus.sum_done = done_q;

endmodule

// File: tb/tb_vector_adder_subtractor.sv
// Directed vector table plus hand sequences for reset, hold and back-to-back starts.
module tb_vector_adder_subtractor;
    import vector_pkg::*;

`ifdef VADDSUB_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam logic [1:0] S8  = 2'b00;
    localparam logic [1:0] S8X = 2'b01;
    localparam logic [1:0] S16 = 2'b10;
    localparam logic [1:0] S32 = 2'b11;

    typedef struct {
        string      name;
        logic [1:0] sew;
        logic       ctrl;
        vec_t       a;
        vec_t       b;
        vec_t       exp;
    } vec_rec_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    vec_rec_t tbl[$];

    vector_adder_subtractor_if bus ();

    vector_adder_subtractor dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Lane k gets ev for even k, od for odd k.
    function automatic vec_t alt(input int unsigned w, input logic [31:0] ev, input logic [31:0] od);
        vec_t v;
        logic [31:0] x;
        v = '0;
        for (int k = 0; k < int'(MAX_VLEN / w); k++) begin
            x = (k % 2 == 0) ? ev : od;
            case (w)
                8:       v[8*k +: 8]   = x[7:0];
                16:      v[16*k +: 16] = x[15:0];
                default: v[32*k +: 32] = x;
            endcase
        end
        return v;
    endfunction

    function automatic vec_t rep(input int unsigned w, input logic [31:0] x);
        return alt(w, x, x);
    endfunction

    task automatic add_vec(input string n, input logic [1:0] s, input logic c,
                           input vec_t a, input vec_t b, input vec_t e);
        vec_rec_t r;
        r.name = n; r.sew = s; r.ctrl = c; r.a = a; r.b = b; r.exp = e;
        tbl.push_back(r);
    endtask

    task automatic chk_vec(input string n, input vec_t act, input vec_t exp);
        int idx;
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            idx = 0;
            for (int k = BYTE_LANES - 1; k >= 0; k--) begin
                if (act[8*k +: 8] !== exp[8*k +: 8]) idx = k;
            end
            $display("FAIL %s: Sum byte %0d got %h want %h (low word got %h want %h)",
                     n, idx, act[8*idx +: 8], exp[8*idx +: 8], act[31:0], exp[31:0]);
        end
    endtask

    task automatic chk_bit(input string n, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", n, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [1:0] sew, input logic c,
                         input vec_t a, input vec_t b);
        bus.start     = s;
        bus.sew_16_32 = sew[1];
        bus.sew_32    = sew[0];
        bus.Ctrl      = c;
        bus.A         = a;
        bus.B         = b;
    endtask

    initial begin
        vec_t pa, pe;
        vec_t last;

        clk     = 1'b0;
        reset   = 1'b1;
        n_tests = 0;
        n_fail  = 0;
        drive(1'b0, S8, 1'b0, '0, '0);

        // 8-bit pattern 08,07,..,01 repeating from byte 0 upward
        for (int k = 0; k < int'(BYTE_LANES); k++) begin
            pa[8*k +: 8] = 8'(8 - (k % 8));
            pe[8*k +: 8] = 8'(9 - (k % 8));
        end
        add_vec("add8_pattern", S8, 1'b0, pa, rep(8, 32'h01), pe);
        add_vec("sub8", S8, 1'b1, rep(8, 32'h10), rep(8, 32'h01), rep(8, 32'h0F));
        add_vec("add8_wrap_isolation", S8, 1'b0, rep(8, 32'hFF), rep(8, 32'h01), rep(8, 32'h00));
        add_vec("sew01_is_8bit", S8X, 1'b0, rep(8, 32'hFF), rep(8, 32'h01), rep(8, 32'h00));
        add_vec("add32_bytes01", S32, 1'b0, rep(8, 32'hFF), rep(8, 32'h01), rep(32, 32'h01010100));
        add_vec("add32_lane_wrap", S32, 1'b0, rep(32, 32'hFFFFFFFF), rep(32, 32'h1), rep(32, 32'h0));

        for (int k = 0; k < int'(MAX_VLEN / 16); k++) begin
            pa[16*k +: 16] = 16'(8 - 2 * (k % 4));
            pe[16*k +: 16] = 16'(9 - 2 * (k % 4));
        end
        add_vec("add16_pattern", S16, 1'b0, pa, rep(16, 32'h1), pe);
        add_vec("add16_byte_carry", S16, 1'b0, rep(16, 32'h00FF), rep(16, 32'h0001), rep(16, 32'h0100));
        add_vec("sub16_byte_borrow", S16, 1'b1, rep(16, 32'h0100), rep(16, 32'h0001), rep(16, 32'h00FF));
        add_vec("add32_alt", S32, 1'b0, alt(32, 32'h4, 32'h2), rep(32, 32'h1), alt(32, 32'h5, 32'h3));
        add_vec("sub32_alt", S32, 1'b1, alt(32, 32'h6, 32'h8), alt(32, 32'h2, 32'h1), alt(32, 32'h4, 32'h7));
        add_vec("sub32_0_minus_1", S32, 1'b1, rep(32, 32'h0), rep(32, 32'h1), rep(32, 32'hFFFFFFFF));

        add_vec("ovf8_pos", S8, 1'b0, rep(8, 32'h7F), rep(8, 32'h01), rep(8, SAT ? 32'h7F : 32'h80));
        add_vec("ovf8_neg", S8, 1'b1, rep(8, 32'h80), rep(8, 32'h01), rep(8, SAT ? 32'h80 : 32'h7F));
        add_vec("ovf16_mixed", S16, 1'b0, alt(16, 32'h7FFF, 32'h0001), rep(16, 32'h1),
                alt(16, SAT ? 32'h7FFF : 32'h8000, 32'h0002));
        add_vec("ovf32_neg", S32, 1'b1, rep(32, 32'h80000000), rep(32, 32'h1),
                rep(32, SAT ? 32'h80000000 : 32'h7FFFFFFF));

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk_vec("reset_sum", bus.Sum, '0);
        chk_bit("reset_done", bus.sum_done, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Table applied back to back: one result per cycle
        foreach (tbl[i]) begin
            drive(1'b1, tbl[i].sew, tbl[i].ctrl, tbl[i].a, tbl[i].b);
            @(posedge clk); #1;
            chk_vec(tbl[i].name, bus.Sum, tbl[i].exp);
            chk_bit({tbl[i].name, "_done"}, bus.sum_done, 1'b1);
            @(negedge clk);
        end
        last = tbl[tbl.size() - 1].exp;

        // start low: result holds even though operands change
        drive(1'b0, S8, 1'b0, rep(8, 32'h33), rep(8, 32'h44));
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk_vec("hold_sum", bus.Sum, last);
            chk_bit("hold_done", bus.sum_done, 1'b0);
            @(negedge clk);
        end

        // Single start: done is a one-cycle pulse
        drive(1'b1, S8, 1'b1, rep(8, 32'h10), rep(8, 32'h01));
        @(posedge clk); #1;
        chk_bit("pulse_done_hi", bus.sum_done, 1'b1);
        @(negedge clk);
        drive(1'b0, S8, 1'b0, '0, '0);
        @(posedge clk); #1;
        chk_bit("pulse_done_lo", bus.sum_done, 1'b0);
        chk_vec("pulse_sum_hold", bus.Sum, rep(8, 32'h0F));
        @(negedge clk);

        // Reset wins over a simultaneous start
        reset = 1'b1;
        drive(1'b1, S8, 1'b0, rep(8, 32'h10), rep(8, 32'h01));
        @(posedge clk); #1;
        chk_vec("reset_with_start_sum", bus.Sum, '0);
        chk_bit("reset_with_start_done", bus.sum_done, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, S8, 1'b0, '0, '0);
        @(posedge clk); #1;
        chk_vec("after_reset_sum", bus.Sum, '0);
        chk_bit("after_reset_done", bus.sum_done, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
